// File: rtl/wb_pipe.sv
// wb_pipe: write-back delay pipeline of DEPTH stages feeding the GPR write
// port, with youngest-first operand bypass from the incoming request and
// from every valid stage.
module wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned FWD_EN = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic              in_e,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic [2:0]        occupancy
);

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [2:0]        r_occ;

  logic              w_acc;
  logic              w_enter;
  logic [DEPTH-1:0]  w_vld_nxt;
  logic [2:0]        w_occ_nxt;

  // Request qualifies for the pipe; register 0 writes are dropped here.
  assign w_acc   = in_valid & in_we & in_e & (in_addr != '0);
  // Request actually lands in stage 0 on the coming edge.
  assign w_enter = w_acc & Reset & ~stall & ~flush;

  // Next valid vector and its population count (flush beats stall).
  always_comb begin
    w_vld_nxt = r_vld;
    if (flush) begin
      w_vld_nxt = '0;
    end else if (!stall) begin
      w_vld_nxt[0] = w_acc;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        w_vld_nxt[k] = r_vld[k-1];
      end
    end
    w_occ_nxt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_occ_nxt = w_occ_nxt + 3'(w_vld_nxt[k]);
    end
  end

  // Stage registers: reset clears, otherwise shift when neither stalled nor flushed.
  // Address/data fields only move along with a valid entry, so the write
  // port fields stay put while no write is pending.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      r_vld <= w_vld_nxt;
      r_occ <= w_occ_nxt;
      if (!stall && !flush) begin
        if (w_acc) begin
          r_addr[0] <= in_addr;
          r_data[0] <= in_data;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
          if (r_vld[k-1]) begin
            r_addr[k] <= r_addr[k-1];
            r_data[k] <= r_data[k-1];
          end
        end
      end
    end
  end

  // Commit port; a pending write is suppressed while reset is asserted.
  assign wr_en     = r_vld[DEPTH-1] & ~stall & Reset;
  assign wr_addr   = r_addr[DEPTH-1];
  assign wr_data   = r_data[DEPTH-1];
  assign occupancy = r_occ;

  // Operand bypass: incoming request first, then stage 0 onward (youngest wins).
  always_comb begin
    opnd_a = rf_a;
    hit_a  = 1'b0;
    opnd_b = rf_b;
    hit_b  = 1'b0;
    if (FWD_EN != 0) begin
      if (raddr_a != '0) begin
        if (w_enter && in_addr == raddr_a) begin
          opnd_a = in_data;
          hit_a  = 1'b1;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!hit_a && r_vld[k] && r_addr[k] == raddr_a) begin
            opnd_a = r_data[k];
            hit_a  = 1'b1;
          end
        end
      end
      if (raddr_b != '0) begin
        if (w_enter && in_addr == raddr_b) begin
          opnd_b = in_data;
          hit_b  = 1'b1;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!hit_b && r_vld[k] && r_addr[k] == raddr_b) begin
            opnd_b = r_data[k];
            hit_b  = 1'b1;
          end
        end
      end
    end
  end

endmodule
